// File: rtl/rr_mux4_arbiter_if.sv
// Handshake bundle between four requesters, the arbiter and one consumer.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface rr_mux4_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          req_valid;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_last;
  logic [3:0]          req_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic                out_ready;
  logic [3:0]          grant;
  logic [1:0]          sel;

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last,
    output grant, sel
  );

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last,
    input  grant, sel
  );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin packet arbiter: four requesters share one output channel,
// the grant is held from the first beat through the beat marked last.
module rr_mux4_arbiter #(
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  rr_mux4_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;
  logic [1:0] ptr;
  logic [1:0] sel_q;
  logic [1:0] win;
  logic       any;
  logic       done;

  // Scan from the farthest slot back to ptr so the nearest one wins.
  always_comb begin
    win = ptr;
    any = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req_valid[ptr + 2'(k)]) begin
        win = ptr + 2'(k);
        any = 1'b1;
      end
    end
  end

  assign done = (state == BUSY) && bus.out_valid
              && bus.out_ready && bus.out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel_q <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state <= BUSY;
            sel_q <= win;
          end
        end
        BUSY: begin
          if (done) begin
            state <= IDLE;
            ptr   <= sel_q + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.req_ready = 4'b0000;
    bus.grant     = 4'b0000;
    if (state == BUSY) begin
      bus.out_valid        = bus.req_valid[sel_q];
      bus.out_data         =
        bus.req_data[int'(sel_q)*DATA_W +: DATA_W];
      bus.out_last         = bus.req_last[sel_q];
      bus.req_ready[sel_q] = bus.out_ready;
      bus.grant[sel_q]     = 1'b1;
    end
  end

  assign bus.sel = sel_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a packet-level model.
module tb_rr_mux4_arbiter;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  rr_mux4_arbiter_if #(.DATA_W(8)) bus ();

  rr_mux4_arbiter #(.DATA_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who owns the channel (-1 = nobody), next priority, last select.
  int m_owner;
  int m_ptr;
  int m_sel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && bus.req_valid[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_sel   = m_owner;
        end
      end
    end else if (bus.req_valid[m_owner] && bus.out_ready
                 && bus.req_last[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] e_grant;
    logic [3:0] e_rdy;
    logic       e_v;
    logic       e_l;
    logic [7:0] e_d;
    e_grant = 4'b0;
    e_rdy   = 4'b0;
    e_v     = 1'b0;
    e_l     = 1'b0;
    e_d     = 8'h00;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_rdy[m_owner]   = bus.out_ready;
      e_v              = bus.req_valid[m_owner];
      e_l              = bus.req_last[m_owner];
      e_d              = bus.req_data[m_owner*8 +: 8];
    end
    chk("m_grant", 32'(bus.grant), 32'(e_grant));
    chk("m_req_ready", 32'(bus.req_ready), 32'(e_rdy));
    chk("m_out_valid", 32'(bus.out_valid), 32'(e_v));
    chk("m_out_last", 32'(bus.out_last), 32'(e_l));
    chk("m_out_data", 32'(bus.out_data), 32'(e_d));
    chk("m_sel", 32'(bus.sel), 32'(m_sel));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setr(input int i, input logic v, input logic [7:0] d,
                      input logic l);
    bus.req_valid[i]       = v;
    bus.req_data[i*8 +: 8] = d;
    bus.req_last[i]        = l;
  endtask

  logic [3:0] exp_g;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.req_valid = 4'b0;
    bus.req_data  = '0;
    bus.req_last  = 4'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_grant", 32'(bus.grant), 32'h0);
      chk("idle_valid", 32'(bus.out_valid), 32'h0);
    end

    // Single requester 2, three beats
    setr(2, 1'b1, 8'h11, 1'b0);
    tick();
    #1;
    chk("r2_grant", 32'(bus.grant), 32'h4);
    chk("r2_d0", 32'(bus.out_data), 32'h11);
    tick();
    setr(2, 1'b1, 8'h22, 1'b0);
    #1;
    chk("r2_d1", 32'(bus.out_data), 32'h22);
    tick();
    setr(2, 1'b1, 8'h33, 1'b1);
    #1;
    chk("r2_d2", 32'(bus.out_data), 32'h33);
    chk("r2_last", 32'(bus.out_last), 32'h1);
    tick();
    setr(2, 1'b0, 8'h00, 1'b0);
    #1;
    chk("r2_idle", 32'(bus.grant), 32'h0);

    // Pointer wrap: r3 finishes, then r0 and r3 together
    setr(3, 1'b1, 8'h30, 1'b1);
    tick();
    chk("r3_grant", 32'(bus.grant), 32'h8);
    tick();
    setr(0, 1'b1, 8'h40, 1'b1);
    tick();
    chk("wrap_grant0", 32'(bus.grant), 32'h1);
    tick();
    setr(0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("wrap_grant3", 32'(bus.grant), 32'h8);
    tick();
    setr(3, 1'b0, 8'h00, 1'b0);

    // Packet lock: r1 owns, drops valid 2 cycles, r0 waiting
    setr(1, 1'b1, 8'h51, 1'b0);
    tick();
    chk("lock_grant", 32'(bus.grant), 32'h2);
    setr(0, 1'b1, 8'h60, 1'b1);
    tick();
    setr(1, 1'b0, 8'h52, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lock_hold", 32'(bus.grant), 32'h2);
      chk("lock_ov", 32'(bus.out_valid), 32'h0);
      chk("lock_rdy", 32'(bus.req_ready), 32'h2);
      tick();
    end
    setr(1, 1'b1, 8'h53, 1'b1);
    tick();
    setr(1, 1'b0, 8'h00, 1'b0);
    #1;
    chk("lock_gap", 32'(bus.req_ready), 32'h0);
    tick();
    chk("lock_r0", 32'(bus.req_ready), 32'h1);
    tick();
    setr(0, 1'b0, 8'h00, 1'b0);

    // Backpressure on requester 2
    bus.out_ready = 1'b0;
    setr(2, 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_rdy", 32'(bus.req_ready), 32'h0);
      chk("bp_data", 32'(bus.out_data), 32'hA5);
      chk("bp_grant", 32'(bus.grant), 32'h4);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_go", 32'(bus.req_ready), 32'h4);
    tick();
    setr(2, 1'b0, 8'h00, 1'b0);
    chk("bp_done", 32'(bus.grant), 32'h0);

    // Reset mid-packet on requester 3
    setr(3, 1'b1, 8'h77, 1'b0);
    tick();
    chk("rm_grant", 32'(bus.grant), 32'h8);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_grant0", 32'(bus.grant), 32'h0);
    chk("rm_valid0", 32'(bus.out_valid), 32'h0);
    chk("rm_data0", 32'(bus.out_data), 32'h0);
    chk("rm_rdy0", 32'(bus.req_ready), 32'h0);
    bus.req_valid = 4'hF;
    bus.req_last  = 4'hF;
    tick();
    rst = 1'b0;
    tick();
    chk("rm_restart", 32'(bus.grant), 32'h1);

    // Fairness: all four single-beat from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_g = (k % 2 == 0) ? 4'(1 << ((k / 2) % 4)) : 4'h0;
      chk("rr_order", 32'(bus.grant), 32'(exp_g));
    end

    // Random traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        setr(i, 1'($urandom_range(0, 2) != 0), 8'($urandom),
             1'($urandom_range(0, 2) == 0));
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      if (n % 700 == 699) rst = 1'b1;
      else rst = 1'b0;
      tick();
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_mux4_arbiter.md
# rr_mux4_arbiter

Round-robin packet arbiter that shares one output channel among four requesters. It drives the select of a 4:1 data multiplexer and holds the grant for a whole packet, from the first beat through the beat marked `last`. Requesters use valid/ready handshakes on both sides. The block sits in front of a single downstream consumer, such as a shared bus, FIFO or serializer.

## Interface
- `DATA_W`, default 8: width of each requester's data beat.
- `clk`  input  1: clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `req_valid`  input  4: per-requester beat valid; bit i belongs to requester i.
- `req_data`  input  4*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last`  input  4: bit i marks the final beat of requester i's packet.
- `req_ready`  output  4: per-requester ready; at most one bit is high in any cycle.
- `out_valid`  output  1: downstream beat valid.
- `out_data`  output  DATA_W: downstream beat data.
- `out_last`  output  1: downstream last-beat flag.
- `out_ready`  input  1: downstream ready.
- `grant`  output  4: one-hot owner of the channel; 0 when idle.
- `sel`  output  2: registered mux select; holds its last value when idle.

## Operation
- States:
  - `IDLE`: no owner.
  - `BUSY`: owner = `sel`.
- Priority pointer `ptr` (2 bits) names the highest-priority requester for the next arbitration.
- IDLE:
  - `grant`=0, `req_ready`=0, `out_valid`=0.
  - If any `req_valid` bit is set, choose the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Register the winner into `sel` and go to BUSY.
  - If no bit is set, stay in IDLE.
- BUSY, combinational pass-through from requester `sel`:
  - `out_valid` = `req_valid[sel]`, `out_data` = requester `sel` data, `out_last` = `req_last[sel]`.
  - `req_ready[sel]` = `out_ready`; every other `req_ready` bit = 0.
  - `grant` = one-hot(`sel`).
- Transfer occurs when `out_valid && out_ready`.
- A transfer with `out_last`=1 ends the packet: next state IDLE, `ptr` <= `sel`+1 (mod 4, wraps 3→0).
- The grant is held until `last` transfers. The owner may drop `req_valid` mid-packet; it keeps the grant and `out_valid`=0 for those cycles.
- Other requesters' valid/data/last are ignored while BUSY, and they never see ready.
- `out_ready` low while BUSY: no transfer, state and `sel` unchanged, outputs follow the owner's inputs.
- The arbiter does not change data width: `out_data` is exactly one requester's beat.

## Timing
- Reset (async assert, clocked deassert) sets:
  - state=IDLE, `ptr`=0, `sel`=0.
  - Outputs: `grant`=0, `req_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
- Reset asserted mid-packet aborts the packet immediately, with no completion beat. After release, arbitration restarts from requester 0.
- Grant latency: 1 cycle.
  - A `req_valid` seen in IDLE at edge N gives `grant` and `out_valid` in cycle N+1.
  - The first transfer can happen in cycle N+1.
- Each packet costs exactly one IDLE cycle after its `last` transfer. Back-to-back single-beat packets from all four requesters therefore reach 50% throughput.
- The transfer path is fully combinational in BUSY: zero-cycle latency from `req_valid[sel]`/`out_ready` to `out_valid`/`req_ready[sel]`.
- A single-beat packet (`last`=1 on the first beat) goes BUSY for one cycle, then IDLE.
- The `ptr` update and the return to IDLE both take effect at the edge that sees the `last` transfer.

## Test plan
- Reset then idle:
  - Stimulus: `rst` high, then low; no requests.
  - Required: `grant`=0, `req_ready`=0, `out_valid`=0 every cycle.
  - Stimulus: `rst` high mid-packet.
  - Required: all outputs 0 within the same cycle; the next grant goes to requester 0.
- Single requester:
  - Stimulus: requester 2 sends a 3-beat packet, data 0x11, 0x22, 0x33, last on 0x33, `out_ready`=1.
  - Required: grant 4'b0100 one cycle after valid; three consecutive transfers with `out_last` on 0x33; IDLE on the next cycle.
- Round-robin fairness:
  - Stimulus: all four requesters hold single-beat packets continuously from reset.
  - Required: grant order 0,1,2,3,0,…; each grant separated by one idle cycle; no requester starves.
- Packet lock:
  - Stimulus: requester 1 owns the channel and drops `req_valid` for 2 cycles mid-packet while requester 0 is requesting.
  - Required: `grant` stays 4'b0010 and `out_valid`=0 for those 2 cycles; requester 0 gets ready only after requester 1's last beat transfers.
- Backpressure:
  - Stimulus: `out_ready` low for 3 cycles during a packet.
  - Required: no transfer and `req_ready` all 0 while low; `out_data` stable; the beat transfers on the first cycle `out_ready`=1.
- Pointer wrap:
  - Stimulus: after requester 3 finishes, requesters 0 and 3 request together.
  - Required: requester 0 is granted first.
